// File: rtl/perm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// perm_seq_ctrl
//
// Sequencer for the 16-lane, 4-bit random-permutation datapath. A run loads
// the identity vector (lane i = i), applies ROUNDS rounds through external
// permutation networks selected by a 16-bit LFSR, then streams the 16 lanes
// out over a valid/ready handshake.
//
// Parameters
//   ROUNDS       permutation rounds per run, 1..255
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        begin a run (sampled only while idle)
//   seed         LFSR seed captured with start; zero is replaced by 1
//   busy         run in progress (ROUND or EMIT)
//   done         one-cycle pulse after the final output handshake
//   perm_sel     permutation network select, valid during ROUND, else 0
//   perm_state   current 16x4-bit state vector, lane i at [4i+3:4i]
//   perm_result  external datapath output for perm_state/perm_sel
//   out_data     emitted lane value
//   out_valid    out_data valid
//   out_ready    consumer ready
//   out_last     asserted with out_valid while lane 15 is presented
// -----------------------------------------------------------------------------
module perm_seq_ctrl #(
    parameter int unsigned ROUNDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] seed,
    output logic        busy,
    output logic        done,
    output logic [2:0]  perm_sel,
    output logic [63:0] perm_state,
    input  logic [63:0] perm_result,
    output logic [3:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    localparam logic [7:0]  LAST_ROUND = 8'(ROUNDS - 1);
    localparam logic [63:0] IDENTITY   = 64'hFEDC_BA98_7654_3210;

    logic [1:0]  st_q,    st_d;
    logic [63:0] state_q, state_d;
    logic [15:0] lfsr_q,  lfsr_d;
    logic [7:0]  rcnt_q,  rcnt_d;
    logic [3:0]  idx_q,   idx_d;
    logic        done_q,  done_d;

    logic        in_round;
    logic        in_emit;
    logic        handshake;
    logic        lfsr_fb;
    logic [3:0]  lane_val;

    assign in_round  = (st_q == S_ROUND);
    assign in_emit   = (st_q == S_EMIT);
    assign handshake = in_emit & out_ready;
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lane_val  = state_q[{idx_q, 2'b00} +: 4];

    // Outputs are decoded from registered state only, so the asynchronous
    // reset clears them immediately and out_valid never sees out_ready.
    assign busy       = (st_q != S_IDLE);
    assign done       = done_q;
    assign perm_sel   = in_round ? lfsr_q[2:0] : 3'd0;
    assign perm_state = state_q;
    assign out_valid  = in_emit;
    assign out_data   = in_emit ? lane_val : 4'd0;
    assign out_last   = in_emit && (idx_q == 4'd15);

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        lfsr_d  = lfsr_q;
        rcnt_d  = rcnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        case (st_q)
            S_IDLE: begin
                if (start) begin
                    state_d = IDENTITY;
                    lfsr_d  = (seed == 16'h0000) ? 16'h0001 : seed;
                    rcnt_d  = '0;
                    st_d    = S_ROUND;
                end
            end

            S_ROUND: begin
                state_d = perm_result;
                lfsr_d  = {lfsr_q[14:0], lfsr_fb};
                rcnt_d  = rcnt_q + 8'd1;
                if (rcnt_q == LAST_ROUND) begin
                    idx_d = '0;
                    st_d  = S_EMIT;
                end
            end

            S_EMIT: begin
                if (handshake) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        st_d   = S_IDLE;
                        done_d = 1'b1;
                    end
                end
            end

            default: begin
                st_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= S_IDLE;
            state_q <= '0;
            lfsr_q  <= 16'h0001;
            rcnt_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_perm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_perm_seq_ctrl
//
// Two sequencer instances share clock, reset, start, seed and out_ready:
//   u_dut3  ROUNDS=3, identity datapath (perm_result = perm_state)
//   u_dut8  ROUNDS=8, bench model of eight fixed permutation networks
// Network k maps output lane i to input lane (A[k]*i + B[k]) mod 16.
// -----------------------------------------------------------------------------
module tb_perm_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    logic        out_ready;

    logic        busy3, done3, valid3, last3;
    logic [2:0]  sel3;
    logic [63:0] state3, result3;
    logic [3:0]  data3;

    logic        busy8, done8, valid8, last8;
    logic [2:0]  sel8;
    logic [63:0] state8, result8;
    logic [3:0]  data8;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    perm_seq_ctrl #(.ROUNDS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .busy(busy3), .done(done3), .perm_sel(sel3), .perm_state(state3),
        .perm_result(result3), .out_data(data3), .out_valid(valid3),
        .out_ready(out_ready), .out_last(last3)
    );

    perm_seq_ctrl #(.ROUNDS(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .busy(busy8), .done(done8), .perm_sel(sel8), .perm_state(state8),
        .perm_result(result8), .out_data(data8), .out_valid(valid8),
        .out_ready(out_ready), .out_last(last8)
    );

    function automatic logic [63:0] apply_perm(input logic [63:0] s, input logic [2:0] k);
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  src;
        logic [63:0] r;
        case (k)
            3'd0: begin a = 4'd1;  b = 4'd1;  end
            3'd1: begin a = 4'd3;  b = 4'd0;  end
            3'd2: begin a = 4'd5;  b = 4'd3;  end
            3'd3: begin a = 4'd7;  b = 4'd5;  end
            3'd4: begin a = 4'd9;  b = 4'd7;  end
            3'd5: begin a = 4'd11; b = 4'd2;  end
            3'd6: begin a = 4'd13; b = 4'd11; end
            default: begin a = 4'd15; b = 4'd13; end
        endcase
        r = '0;
        for (int i = 0; i < 16; i++) begin
            src = 4'(a * 4'(i) + b);
            r[i*4 +: 4] = s[{src, 2'b00} +: 4];
        end
        return r;
    endfunction

    assign result3 = state3;
    always_comb result8 = apply_perm(state8, sel8);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((busy3 || busy8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_idle", {busy3, busy8}, 2'b00);
    endtask

    // Identity-datapath run on u_dut3. Entered at a negedge; returns at the
    // negedge of the done cycle so a caller may start again right there.
    task automatic id_run(input logic [15:0] sd, input logic [2:0] e0,
                          input logic [2:0] e1, input logic [2:0] e2,
                          input int p1, input int p2);
        logic [2:0] esel [3];
        esel[0] = e0; esel[1] = e1; esel[2] = e2;
        seed  = sd;
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) check_eq("id_busy_rise", busy3, 1'b1);
            if (c < 3) begin
                check_eq($sformatf("id_sel%0d", c), sel3, esel[c]);
                check_eq($sformatf("id_novalid%0d", c), valid3, 1'b0);
            end else if (c < 19) begin
                check_eq($sformatf("id_data%0d", c - 3), {valid3, last3, data3},
                         {1'b1, (c == 18), 4'(c - 3)});
                check_eq($sformatf("id_sel_emit%0d", c), sel3, 3'd0);
                check_eq($sformatf("id_done_early%0d", c), done3, 1'b0);
            end else begin
                check_eq("id_done", {done3, busy3, valid3}, 3'b100);
            end
            start = (c == p1 || c == p2);
        end
        start = 1'b0;
    endtask

    logic [2:0]  ace_sel [8];
    logic [63:0] exp_state;
    logic [15:0] seen;

    initial begin
        ace_sel[0] = 3'd1; ace_sel[1] = 3'd3; ace_sel[2] = 3'd7; ace_sel[3] = 3'd7;
        ace_sel[4] = 3'd6; ace_sel[5] = 3'd4; ace_sel[6] = 3'd1; ace_sel[7] = 3'd2;

        rst = 1'b1; start = 1'b0; seed = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_outs3", {busy3, done3, valid3, last3, data3, sel3}, '0);
        check_eq("rst_state3", state3, 64'h0);
        check_eq("rst_outs8", {busy8, done8, valid8, sel8}, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_after_rst", {busy3, busy8}, 2'b00);

        // Identity run, seed 0 -> lfsr 1: selects 1,2,4; then back-to-back
        // start in the done cycle with seed 5: lfsr 5,A,14 -> selects 5,2,4.
        id_run(16'h0000, 3'd1, 3'd2, 3'd4, -1, -1);
        id_run(16'h0005, 3'd5, 3'd2, 3'd4, -1, -1);
        wait_idle();

        // start pulses during ROUND (c=1) and EMIT (c=10) are ignored.
        id_run(16'h0000, 3'd1, 3'd2, 3'd4, 1, 10);
        wait_idle();

        // Full datapath, ROUNDS=8, seed ACE1.
        exp_state = 64'hFEDC_BA98_7654_3210;
        seen = '0;
        seed = 16'hACE1;
        start = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c < 8) begin
                check_eq($sformatf("full_state%0d", c), state8, exp_state);
                check_eq($sformatf("full_sel%0d", c), sel8, ace_sel[c]);
                exp_state = apply_perm(exp_state, ace_sel[c]);
            end else if (c < 24) begin
                check_eq($sformatf("full_lane%0d", c - 8), {valid8, last8, data8},
                         {1'b1, (c == 23), exp_state[(c - 8)*4 +: 4]});
                seen[data8] = 1'b1;
            end else begin
                check_eq("full_done", {done8, busy8}, 2'b10);
            end
        end
        check_eq("full_is_perm", seen, 16'hFFFF);
        wait_idle();

        // Backpressure on u_dut3, ready pattern 1,0,0 repeating.
        begin
            int unsigned n = 0;
            int unsigned e = 0;
            int unsigned k = 0;
            logic        stall = 1'b0;
            logic [4:0]  prev = '0;
            seed = 16'h0000;
            start = 1'b1;
            while (n < 16 && k < 100) begin
                @(negedge clk);
                start = 1'b0;
                k++;
                if (valid3) begin
                    out_ready = (e % 3 == 0);
                    e++;
                    if (stall) check_eq($sformatf("bp_hold%0d", n), {last3, data3}, prev);
                    if (out_ready) begin
                        check_eq($sformatf("bp_lane%0d", n), {last3, data3}, {(n == 15), 4'(n)});
                        n++;
                    end
                    stall = !out_ready;
                    prev  = {last3, data3};
                end
            end
            check_eq("bp_count", n, 16);
            @(negedge clk);
            out_ready = 1'b1;
            check_eq("bp_done", {done3, busy3}, 2'b10);
        end
        wait_idle();

        // Asynchronous reset while u_dut3 emits and u_dut8 is mid-ROUND.
        seed = 16'hACE1;
        start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("pre_rst_valid3", valid3, 1'b1);
        check_eq("pre_rst_sel8", sel8, ace_sel[5]);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst3", {valid3, busy3, sel3, done3}, '0);
        check_eq("async_rst8", {busy8, sel8, valid8}, '0);
        check_eq("async_rst_state", state3 | state8, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("post_rst_idle", {busy3, busy8, done3, done8, valid3, valid8}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
